// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared encodings for the pipeline hazard controller
// Contents: controller state encoding, register-0 constant.
package cpu_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      FREEZE    = 2'd1,
      FREEZE_BR = 2'd2
   } hz_state_e;

   localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// rtl/pipeline_hazard_ctrl_sat_counter.sv - saturating up-counter for performance debug
// Ports: clk, reset (async active-low), inc (count one), count (holds at all-ones).
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else if (inc && (count_q != {W{1'b1}})) begin
         count_q <= count_q + {{(W-1){1'b0}}, 1'b1};
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - load-use stall, branch flush and memory freeze control
// Ports: clk, reset (async active-low); IF/ID and ID/EXE operand fields for the
// load-use check; branchTaken, memBusy; write enables for PC and the four
// pipeline registers; bubble requests for IF/ID, ID/EXE, EXE/MEM; saturating
// stallCycles / flushCount counters.
module pipeline_hazard_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       ifIdRs,
   input  logic [4:0]       ifIdRt,
   input  logic             ifIdUsesRt,
   input  logic             idExeMemRead,
   input  logic [4:0]       idExeRt,
   input  logic             branchTaken,
   input  logic             memBusy,
   output logic             pcWrite,
   output logic             ifIdWrite,
   output logic             idExeWrite,
   output logic             exeMemWrite,
   output logic             memWbWrite,
   output logic             ifIdFlush,
   output logic             idExeFlush,
   output logic             exeMemFlush,
   output logic [CNT_W-1:0] stallCycles,
   output logic [CNT_W-1:0] flushCount
);

   hz_state_e  state_q, state_d;
   logic [4:0] wr_en;      // {pc, ifId, idExe, exeMem, memWb}
   logic [2:0] flush;      // {ifId, idExe, exeMem}
   logic       stall_inc;
   logic       flush_inc;
   logic       load_use;
   logic       br_pend;

   assign load_use = idExeMemRead && (idExeRt != REG_ZERO) &&
                     ((idExeRt == ifIdRs) || (ifIdUsesRt && (idExeRt == ifIdRt)));

   // A branch latched during a freeze is replayed on the first non-busy cycle.
   assign br_pend = branchTaken || (state_q == FREEZE_BR);

   always_comb begin
      state_d   = state_q;
      wr_en     = 5'b00000;
      flush     = 3'b000;
      stall_inc = 1'b0;
      flush_inc = 1'b0;
      if (memBusy) begin
         stall_inc = 1'b1;
         state_d   = br_pend ? FREEZE_BR : FREEZE;
      end else begin
         state_d = RUN;
         if (br_pend) begin
            // Flush wins over load-use: the dependent instruction is discarded.
            wr_en     = 5'b11111;
            flush     = 3'b111;
            flush_inc = 1'b1;
         end else if (load_use) begin
            wr_en     = 5'b00111;
            flush     = 3'b010;
            stall_inc = 1'b1;
         end else begin
            wr_en = 5'b11111;
         end
      end
      // Outputs are Mealy, so reset must mask them combinationally.
      if (!reset) begin
         wr_en     = 5'b00000;
         flush     = 3'b000;
         stall_inc = 1'b0;
         flush_inc = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   assign {pcWrite, ifIdWrite, idExeWrite, exeMemWrite, memWbWrite} = wr_en;
   assign {ifIdFlush, idExeFlush, exeMemFlush} = flush;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (stall_inc),
      .count (stallCycles)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (flush_inc),
      .count (flushCount)
   );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [4:0]    ifIdRs = '0, ifIdRt = '0, idExeRt = '0;
   logic          ifIdUsesRt = 1'b0, idExeMemRead = 1'b0, branchTaken = 1'b0, memBusy = 1'b0;
   logic          pcWrite, ifIdWrite, idExeWrite, exeMemWrite, memWbWrite;
   logic          ifIdFlush, idExeFlush, exeMemFlush;
   logic [CW-1:0] stallCycles, flushCount;

   int checks = 0;
   int errors = 0;

   // model state: counters and whether a taken branch is waiting out a freeze
   int m_stall = 0;
   int m_flush = 0;
   bit m_br_wait = 0;
   bit run_cmp = 0;

   pipeline_hazard_ctrl #(.CNT_W(CW)) dut (
      .clk(clk), .reset(reset),
      .ifIdRs(ifIdRs), .ifIdRt(ifIdRt), .ifIdUsesRt(ifIdUsesRt),
      .idExeMemRead(idExeMemRead), .idExeRt(idExeRt),
      .branchTaken(branchTaken), .memBusy(memBusy),
      .pcWrite(pcWrite), .ifIdWrite(ifIdWrite), .idExeWrite(idExeWrite),
      .exeMemWrite(exeMemWrite), .memWbWrite(memWbWrite),
      .ifIdFlush(ifIdFlush), .idExeFlush(idExeFlush), .exeMemFlush(exeMemFlush),
      .stallCycles(stallCycles), .flushCount(flushCount)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] dut_vec();
      return {pcWrite, ifIdWrite, idExeWrite, exeMemWrite, memWbWrite,
              ifIdFlush, idExeFlush, exeMemFlush};
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle model: expected controls from the rules, then post-edge state.
   always @(negedge clk) begin
      if (run_cmp) begin
         bit         lu;
         logic [7:0] ev;
         if (!reset) begin
            m_stall = 0; m_flush = 0; m_br_wait = 0;
         end
         lu = idExeMemRead && idExeRt != 0 &&
              (idExeRt == ifIdRs || (ifIdUsesRt && idExeRt == ifIdRt));
         if (!reset || memBusy)              ev = 8'b00000_000;
         else if (branchTaken || m_br_wait)  ev = 8'b11111_111;
         else if (lu)                        ev = 8'b00111_010;
         else                                ev = 8'b11111_000;
         check("model_ctrl", dut_vec(), ev);
         check("model_stall", stallCycles, m_stall);
         check("model_flush", flushCount, m_flush);
         if (reset) begin
            if (memBusy) begin
               if (m_stall < 15) m_stall++;
               if (branchTaken) m_br_wait = 1;
            end else if (branchTaken || m_br_wait) begin
               if (m_flush < 15) m_flush++;
               m_br_wait = 0;
            end else if (lu) begin
               if (m_stall < 15) m_stall++;
            end
         end
      end
   end

   task automatic drive(input bit busy, input bit br, input bit mr, input int exrt,
                        input int rs, input int rt, input bit usesrt);
      @(posedge clk); #1;
      memBusy = busy; branchTaken = br; idExeMemRead = mr;
      idExeRt = exrt[4:0]; ifIdRs = rs[4:0]; ifIdRt = rt[4:0]; ifIdUsesRt = usesrt;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b0;
      memBusy = 1'b1; branchTaken = 1'b1; idExeMemRead = 1'b1;
      idExeRt = 5'd7; ifIdRs = 5'd7; ifIdRt = 5'd7; ifIdUsesRt = 1'b1;
      @(negedge clk);
      check("reset_ctrl", dut_vec(), 0);
      check("reset_stall", stallCycles, 0);
      check("reset_flush", flushCount, 0);
      @(posedge clk); #1;
      reset = 1'b1;
      memBusy = 0; branchTaken = 0; idExeMemRead = 0;
      idExeRt = 0; ifIdRs = 0; ifIdRt = 0; ifIdUsesRt = 0;
   endtask

   initial begin
      #1 reset = 1'b0;
      run_cmp = 1'b1;
      do_reset();

      // load-use on rs: one bubble, then normal with stallCycles = 1
      drive(0, 0, 1, 5, 5, 0, 0);
      @(negedge clk); check("lu_ctrl", dut_vec(), 8'b00111_010);
      idle();
      @(negedge clk); check("lu_after_ctrl", dut_vec(), 8'b11111_000);
      check("lu_after_stall", stallCycles, 1);

      // load-use on rt only when the instruction reads rt
      drive(0, 0, 1, 9, 0, 9, 1);
      @(negedge clk); check("lu_rt_ctrl", dut_vec(), 8'b00111_010);

      // register 0 never hazards; rt match ignored without ifIdUsesRt
      drive(0, 0, 1, 0, 0, 0, 1);
      @(negedge clk); check("r0_ctrl", dut_vec(), 8'b11111_000);
      drive(0, 0, 1, 5, 3, 5, 0);
      @(negedge clk); check("rt_unused_ctrl", dut_vec(), 8'b11111_000);
      idle();

      // branch beats load-use
      do_reset();
      drive(0, 1, 1, 5, 5, 5, 1);
      @(negedge clk); check("br_lu_ctrl", dut_vec(), 8'b11111_111);
      idle();
      @(negedge clk); check("br_lu_flush", flushCount, 1);
      check("br_lu_stall", stallCycles, 0);

      // 3-cycle freeze with a branch pulsed in the second busy cycle
      do_reset();
      drive(1, 0, 0, 0, 0, 0, 0);
      @(negedge clk); check("frz1_ctrl", dut_vec(), 0);
      drive(1, 1, 0, 0, 0, 0, 0);
      @(negedge clk); check("frz2_ctrl", dut_vec(), 0);
      drive(1, 0, 0, 0, 0, 0, 0);
      @(negedge clk); check("frz3_ctrl", dut_vec(), 0);
      idle();
      @(negedge clk); check("frz_br_ctrl", dut_vec(), 8'b11111_111);
      idle();
      @(negedge clk); check("frz_end_ctrl", dut_vec(), 8'b11111_000);
      check("frz_stall", stallCycles, 3);
      check("frz_flush", flushCount, 1);

      // plain freeze returns to RUN and evaluates load-use in the release cycle
      do_reset();
      drive(1, 0, 1, 6, 6, 0, 0);
      @(negedge clk); check("frz_lu_busy", dut_vec(), 0);
      drive(0, 0, 1, 6, 6, 0, 0);
      @(negedge clk); check("frz_lu_rel", dut_vec(), 8'b00111_010);
      idle();

      // reset during a pending-branch freeze drops the branch
      drive(1, 1, 0, 0, 0, 0, 0);
      do_reset();
      @(negedge clk); check("rst_mid_ctrl", dut_vec(), 8'b11111_000);
      check("rst_mid_flush", flushCount, 0);

      // saturation of the 4-bit stall counter
      for (int i = 0; i < 20; i++) drive(1, 0, 0, 0, 0, 0, 0);
      idle();
      @(negedge clk); check("sat_stall", stallCycles, 15);
      drive(0, 0, 1, 4, 4, 0, 0);
      idle();
      @(negedge clk); check("sat_hold", stallCycles, 15);

      @(posedge clk); #1;
      run_cmp = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and sequencing controller for the 5-stage MIPS pipeline. It drives the write enables and bubble (flush) requests of the PC and the four pipeline registers (IF/ID, ID/EXE, EXE/MEM, MEM/WB). It handles three cases: load-use stalls, taken-branch flushes and whole-pipeline freezes while data memory is busy. It also keeps saturating stall and flush counters for performance debug. It sits beside the datapath in the CPU top level; every pipeline register's `write` input is wired from this block.

## Interface
- `CNT_W`, 16, width of the performance counters
- `clk`  in  1  pipeline clock, rising edge
- `reset`  in  1  asynchronous, active-low; clears state and counters
- `ifIdRs`  in  5  rs field of the instruction in IF/ID
- `ifIdRt`  in  5  rt field of the instruction in IF/ID
- `ifIdUsesRt`  in  1  IF/ID instruction reads rt (R-type, beq, sw)
- `idExeMemRead`  in  1  instruction in ID/EXE is a load
- `idExeRt`  in  5  destination rt of the instruction in ID/EXE
- `branchTaken`  in  1  branch resolved taken, from EXE/MEM outputs
- `memBusy`  in  1  data memory has not completed its access this cycle
- `pcWrite`, `ifIdWrite`, `idExeWrite`, `exeMemWrite`, `memWbWrite`  out  1 each  load enables
- `ifIdFlush`, `idExeFlush`, `exeMemFlush`  out  1 each  load a bubble (all control bits 0) on the next edge
- `stallCycles`  out  CNT_W  count of load-use stall cycles plus freeze cycles, saturating
- `flushCount`  out  CNT_W  count of branch flushes performed, saturating

## Operation
- States:
  - RUN: normal operation.
  - FREEZE: memory busy, no branch pending.
  - FREEZE_BR: memory busy, a taken branch is latched.
- Load-use hazard:
  - Condition: `loadUse = idExeMemRead && idExeRt != 0 && (idExeRt == ifIdRs || (ifIdUsesRt && idExeRt == ifIdRt))`.
- Decision priority within a cycle: freeze > branch flush > load-use stall.
- RUN, `memBusy`=1:
  - All write enables are 0 and all flushes are 0.
  - Next state is FREEZE_BR if `branchTaken`, else FREEZE.
- RUN, `branchTaken`=1, `memBusy`=0:
  - All write enables are 1.
  - `ifIdFlush`, `idExeFlush` and `exeMemFlush` are 1.
  - `flushCount` increments.
  - A load-use hazard in the same cycle is ignored, because the dependent instruction is being flushed.
- RUN, `loadUse`=1, no branch, no busy:
  - `pcWrite` and `ifIdWrite` are 0.
  - `idExeWrite`, `exeMemWrite` and `memWbWrite` are 1.
  - `idExeFlush` is 1.
  - `stallCycles` increments.
- FREEZE:
  - All write enables are 0 and all flushes are 0.
  - `stallCycles` increments each cycle.
  - A `branchTaken` seen here moves the state to FREEZE_BR.
  - Return to RUN in the first cycle `memBusy`=0. That cycle's outputs are evaluated as RUN.
- FREEZE_BR:
  - Behaves as FREEZE while busy.
  - In the first cycle with `memBusy`=0, perform the branch flush (as above, `flushCount` increments), then go to RUN.
- Counters saturate at all-ones and never wrap.
- While `reset`=0: all write enables 0, all flushes 0, state RUN, counters 0.

## Timing
- Outputs are Mealy: combinational from the current state and the inputs, valid in the same cycle. The pipeline registers sample them at the next rising edge.
- State and counters update on the rising `clk` edge.
- Load-use costs exactly 1 bubble. In the following cycle, ID/EXE holds the bubble, so `loadUse` is 0 with no extra state.
- A branch flush takes 1 cycle. The redirected PC is loaded by the datapath in the same edge (`pcWrite`=1).
- Freeze latency is 0: a `memBusy` asserted in cycle N blocks the edge that ends cycle N.
- Reset assertion takes effect immediately, even mid-freeze or with a pending branch. After deassertion, the first edge sees state RUN.

## Structure
- A shared `cpu_ctrl_pkg` holds:
  - the state encoding constants (RUN=2'd0, FREEZE=2'd1, FREEZE_BR=2'd2);
  - the register-0 constant.
- One sub-module, `sat_counter`, parameterised by width with `inc`, `clk` and `reset` inputs, is instantiated twice.
- The hazard comparator stays inline.

## Test plan
- Reset low with arbitrary inputs → all write enables 0, all flushes 0, `stallCycles`=0, `flushCount`=0. Release reset → RUN.
- `idExeMemRead`=1, `idExeRt`=5, `ifIdRs`=5 → one cycle with `pcWrite`=`ifIdWrite`=0 and `idExeFlush`=1. Next cycle: normal, and `stallCycles`=1.
- `idExeRt`=0 with matching `ifIdRs`=0 → no stall. `ifIdRt`=5 match with `ifIdUsesRt`=0 → no stall.
- `branchTaken`=1 together with a load-use hazard → all three flushes asserted, `pcWrite`=1, `flushCount`=1, `stallCycles` unchanged.
- `memBusy` high for 3 cycles, with `branchTaken` pulsed in the second busy cycle → 3 frozen cycles, then one flush cycle in which `memBusy`=0. `stallCycles`=3, `flushCount`=1.
- Preload a counter near all-ones (CNT_W=4) and apply 20 stall cycles → `stallCycles` holds at 15.
